// File: rtl/df_seq_o.sv
// df_seq_o : output-neuron operand sequencer.
//   Snapshots N_IN input words on start, then streams them one per accepted
//   beat over a valid/ready handshake, optionally followed by a constant
//   bias word. A one-cycle done pulse follows acceptance of the last beat.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      begin a sweep (sampled only while idle)
//   data_in    flat input bus, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_ready  downstream accepts the current beat
//   out_valid  out_data/out_idx/out_last hold a valid beat
//   out_data   current operand (register driven)
//   out_idx    beat index: 0..N_IN-1 data, N_IN bias
//   out_last   final beat of the sweep
//   busy       sweep in progress (STREAM or FIN)
//   done       one-cycle pulse after the last beat is accepted
module df_seq_o #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           N_IN       = 15,
  parameter int unsigned           IDX_W      = 8,
  parameter int unsigned           BIAS_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] BIAS_CONST = 16'h1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N_IN*DATA_WIDTH-1:0] data_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FIN    = 2'd2;

  localparam int unsigned      LAST     = N_IN - 1 + BIAS_EN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] snap_q [N_IN];
  logic [DATA_WIDTH-1:0] snap_d [N_IN];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic [IDX_W-1:0]      nxt_idx;
  logic [DATA_WIDTH-1:0] nxt_word;

  // Word for the beat after the current one; indices past the data
  // channels select the bias constant.
  always_comb begin
    nxt_idx  = idx_q + 1'b1;
    nxt_word = BIAS_CONST;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (nxt_idx == IDX_W'(k)) nxt_word = snap_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < N_IN; k++) begin
            snap_d[k] = data_in[k*DATA_WIDTH +: DATA_WIDTH];
          end
          // First beat is loaded straight into the output register in the
          // same edge as the snapshot, so it appears one cycle after start.
          data_d  = data_in[DATA_WIDTH-1:0];
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (LAST == 0);
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (valid_q && out_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            idx_d  = nxt_idx;
            data_d = nxt_word;
            last_d = (nxt_idx == LAST_IDX);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      for (int unsigned k = 0; k < N_IN; k++) begin
        snap_q[k] <= '0;
      end
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_df_seq_o.sv
module tb_df_seq_o;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int NA = 15;
  localparam int NB = 4;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic out_ready = 1'b0;
  logic [NA*DW-1:0] din_a = '0;
  logic [NB*DW-1:0] din_b = '0;

  logic a_valid, a_last, a_busy, a_done;
  logic [DW-1:0] a_data;
  logic [IW-1:0] a_idx;
  logic b_valid, b_last, b_busy, b_done;
  logic [DW-1:0] b_data;
  logic [IW-1:0] b_idx;

  logic sel_b = 1'b0;
  logic m_valid, m_last, m_busy, m_done;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_idx;

  beat_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int busy_cnt = 0;
  logic mon_en = 1'b0;
  logic done_due = 1'b0;
  logic stall_prev = 1'b0;

  always #5 clk = ~clk;

  df_seq_o dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .data_in(din_a),
    .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data),
    .out_idx(a_idx), .out_last(a_last), .busy(a_busy), .done(a_done)
  );

  df_seq_o #(.DATA_WIDTH(16), .N_IN(4), .IDX_W(8), .BIAS_EN(0),
             .BIAS_CONST(16'h1000)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .data_in(din_b),
    .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data),
    .out_idx(b_idx), .out_last(b_last), .busy(b_busy), .done(b_done)
  );

  assign m_valid = sel_b ? b_valid : a_valid;
  assign m_last  = sel_b ? b_last  : a_last;
  assign m_busy  = sel_b ? b_busy  : a_busy;
  assign m_done  = sel_b ? b_done  : a_done;
  assign m_data  = sel_b ? b_data  : a_data;
  assign m_idx   = sel_b ? b_idx   : a_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_vec++;
    assert (obs === expd) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  task automatic push_exp(input int n, input bit bias, input logic [NA*DW-1:0] d);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = IW'(k);
      e.data = d[k*DW +: DW];
      e.last = (k == n - 1 + int'(bias));
      sb.push_back(e);
    end
    if (bias) begin
      e.idx  = IW'(n);
      e.data = 16'h1000;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  task automatic monitor();
    beat_t e;
    logic nxt_due;
    nxt_due = 1'b0;
    chk("done_with_valid", {31'b0, m_done & m_valid}, 32'd0);
    chk("done_timing", {31'b0, m_done}, {31'b0, done_due});
    if (stall_prev) chk("valid_held", {31'b0, m_valid}, 32'd1);
    if (m_busy) busy_cnt++;
    if (m_done) done_cnt++;
    if (m_valid) begin
      chk("beat_expected", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("idx", {24'b0, m_idx}, {24'b0, e.idx});
        chk("data", {16'b0, m_data}, {16'b0, e.data});
        chk("last", {31'b0, m_last}, {31'b0, e.last});
        if (out_ready) begin
          void'(sb.pop_front());
          beat_cnt++;
          nxt_due = e.last;
        end
      end
    end
    stall_prev = m_valid && !out_ready;
    done_due   = nxt_due;
  endtask

  task automatic cyc();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic go_a();
    start_a = 1'b1;
    push_exp(NA, 1'b1, din_a);
    cyc();
    start_a = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) cyc();
    chk(tag, done_cnt, d0 + 1);
  endtask

  task automatic wait_idx(input logic [IW-1:0] target);
    int i;
    i = 0;
    while (!(a_valid && a_idx == target) && i < 100) begin
      cyc();
      i++;
    end
    chk("reach_idx", {31'b0, a_valid && a_idx == target}, 32'd1);
  endtask

  initial begin
    int d0;
    int i;
    logic [NA*DW-1:0] pat;

    for (int k = 0; k < NA; k++) pat[k*DW +: DW] = 16'(16'h0100 * k + k);

    // Reset state
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_done", {31'b0, a_done}, 32'd0);
    chk("rst_idx", {24'b0, a_idx}, 32'd0);
    chk("rst_data", {16'b0, a_data}, 32'd0);
    chk("rst_last", {31'b0, a_last}, 32'd0);
    chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc();

    // Basic sweep with ready held high
    out_ready = 1'b1;
    din_a = pat;
    busy_cnt = 0;
    beat_cnt = 0;
    go_a();
    wait_done("basic_done");
    cyc();
    cyc();
    chk("basic_busy_cycles", busy_cnt, 17);
    chk("basic_beats", beat_cnt, 16);
    chk("basic_sb_empty", sb.size(), 0);

    // Backpressure: ready pattern 1,0,0 repeating
    beat_cnt = 0;
    din_a = ~pat;
    go_a();
    d0 = done_cnt;
    for (int c = 0; c < 300 && done_cnt == d0; c++) begin
      out_ready = (c % 3 == 0);
      cyc();
    end
    chk("bp_done", done_cnt, d0 + 1);
    out_ready = 1'b1;
    cyc();
    chk("bp_beats", beat_cnt, 16);
    chk("bp_sb_empty", sb.size(), 0);

    // Snapshot isolation: inputs go to all-ones right after start
    for (int k = 0; k < NA; k++) din_a[k*DW +: DW] = 16'(16'hA000 + 16'h0011 * k);
    go_a();
    din_a = '1;
    wait_done("iso_done");
    cyc();
    chk("iso_sb_empty", sb.size(), 0);

    // Start while busy: at beat 5 and during FIN
    for (int k = 0; k < NA; k++) din_a[k*DW +: DW] = 16'(16'h5000 + k);
    d0 = done_cnt;
    go_a();
    din_a = {NA{16'h7777}};
    wait_idx(8'd5);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    i = 0;
    while (!a_done && i < 100) begin
      cyc();
      i++;
    end
    chk("busy_fin_reached", {31'b0, a_done}, 32'd1);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (25) cyc();
    chk("busy_single_done", done_cnt, d0 + 1);
    chk("busy_no_restart", {31'b0, a_busy}, 32'd0);
    chk("busy_sb_empty", sb.size(), 0);

    // Reset mid-sweep at beat 7
    din_a = pat;
    go_a();
    wait_idx(8'd7);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    sb.delete();
    stall_prev = 1'b0;
    chk("mrst_valid", {31'b0, a_valid}, 32'd0);
    chk("mrst_busy", {31'b0, a_busy}, 32'd0);
    chk("mrst_idx", {24'b0, a_idx}, 32'd0);
    chk("mrst_data", {16'b0, a_data}, 32'd0);
    chk("mrst_done", {31'b0, a_done}, 32'd0);
    d0 = done_cnt;
    repeat (20) cyc();
    chk("mrst_no_done", done_cnt, d0);
    beat_cnt = 0;
    go_a();
    wait_done("mrst_fresh_done");
    cyc();
    chk("mrst_fresh_beats", beat_cnt, 16);
    chk("mrst_sb_empty", sb.size(), 0);

    // No-bias instance, N_IN=4
    sel_b = 1'b1;
    cyc();
    beat_cnt = 0;
    din_b = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    start_b = 1'b1;
    push_exp(NB, 1'b0, {{(NA-NB)*DW{1'b0}}, din_b});
    cyc();
    start_b = 1'b0;
    wait_done("nb_done");
    repeat (3) cyc();
    chk("nb_beats", beat_cnt, 4);
    chk("nb_sb_empty", sb.size(), 0);
    chk("nb_idle", {31'b0, b_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/df_seq_o.md
Name: df_seq_o

Overview:
- Parametrised successor to the output-neuron operand mux.
- On `start`, snapshots N_IN neuron-input words and streams them one per accepted beat to the downstream MAC/accumulator.
- After the data words it appends an optional constant bias word (default 1.0 in Q4.12).
- Uses a valid/ready handshake, so the MAC can stall without losing or reordering operands. This replaces the external `sel` counter plus combinational mux.

Parameters:
- DATA_WIDTH, 16, word width (Q4.12 fixed point).
- N_IN, 15, number of data channels, 1..255.
- IDX_W, 8, width of the beat index. Must satisfy 2^IDX_W > N_IN.
- BIAS_EN, 1, 1 = append bias beat after the data beats, 0 = no bias beat.
- BIAS_CONST, 16'h1000, value of the bias beat (1.0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request a new sweep. Sampled only in IDLE.
- data_in  in  N_IN*DATA_WIDTH  flat input bus. Channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_ready  in  1  downstream accepts the current beat
- out_valid  out  1  out_data holds a valid operand
- out_data  out  DATA_WIDTH  current operand
- out_idx  out  IDX_W  beat index: 0..N_IN-1 for data, N_IN for bias
- out_last  out  1  marks the final beat of the sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
  - Snapshot registers cleared to 0.
  - Reset overrides every other input, including mid-sweep. An in-flight sweep is abandoned with no done pulse.
- States: IDLE, STREAM, FIN.
- IDLE:
  - On start==1, every channel of data_in is captured into the snapshot registers.
  - Next state is STREAM. out_valid=1, out_data=snap[0], out_idx=0, busy=1.
  - The first beat is therefore presented one cycle after start.
  - Later changes on data_in do not affect the sweep.
- STREAM:
  - A beat transfers on a clock edge where out_valid & out_ready.
  - On transfer with out_idx < LAST, out_idx increments and out_data loads the next word:
    - snap[idx+1] if idx+1 < N_IN;
    - otherwise BIAS_CONST.
  - Without transfer, out_data, out_idx and out_last hold stable.
  - out_valid must not drop while waiting for ready.
- LAST = N_IN-1+BIAS_EN.
  - out_last=1 exactly while out_idx==LAST and out_valid=1.
- On transfer of the LAST beat: next state FIN, out_valid=0, out_last=0.
- FIN (one cycle):
  - done=1 and busy=1. Next state IDLE, where busy=0 and done=0.
  - A start asserted during FIN is ignored.
- Start while busy (STREAM or FIN) is ignored. The snapshot is not overwritten.
- Throughput: with out_ready held high, one beat per cycle.
  - A sweep occupies N_IN+BIAS_EN STREAM cycles plus 1 FIN cycle.
  - The next start is accepted in the cycle after FIN, so the minimum start-to-start period is N_IN+BIAS_EN+2 cycles.
- Degenerate case N_IN=1, BIAS_EN=0:
  - A single beat, presented with out_last=1.
  - FIN follows immediately on its transfer.
- out_data is driven only from registers; there is no combinational path from data_in to out_data.
- done and out_valid are never high in the same cycle.

Test Plan:
- Basic sweep (N_IN=15, BIAS_EN=1, out_ready=1):
  - Stimulus: data_in channel k = 16'h0100*k + k; pulse start.
  - Required:
    - 16 consecutive beats: out_idx 0..15, out_data 0x0000, 0x0101, ..., 0x0E0E, 0x1000.
    - out_last only on idx 15.
    - done pulses one cycle after the idx-15 transfer.
    - busy is high for 17 cycles.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... during the sweep.
  - Required:
    - Each beat appears exactly once, in order.
    - out_data and out_idx are unchanged across stall cycles.
    - Total beats = 16.
- Snapshot isolation:
  - Stimulus: change every data_in channel to 0xFFFF the cycle after start.
  - Required: the streamed data words equal the pre-start values, never 0xFFFF.
- Start while busy:
  - Stimulus: assert start at beat 5 and again during FIN.
  - Required: the sweep completes unchanged with a single done pulse, and no second sweep begins.
- Reset mid-sweep:
  - Stimulus: drive reset=0 for one cycle at beat 7.
  - Required: the next cycle shows out_valid=0, busy=0, out_idx=0, out_data=0, and no done pulse.
  - A fresh start afterwards runs a full 16-beat sweep.
- No bias (BIAS_EN=0, N_IN=4):
  - Stimulus: data_in = {0x0004, 0x0003, 0x0002, 0x0001} from channel 3 down to channel 0; pulse start.
  - Required: 4 beats 0x0001..0x0004, out_last on idx 3, no BIAS_CONST beat, done one cycle later.
